// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Multi-cycle restoring divider, WIDTH bits, one quotient bit per
//            clock. start/busy/done handshake, divide-by-zero flag, results
//            held until the next accepted operation.
// Optional : define SEQ_DIVIDER_SIGNED_EN to add the signed_op input
//            (two's-complement operands, quotient truncated toward zero,
//            remainder takes the sign of the dividend).
// Ports    :
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   start      in   request a division (sampled in IDLE or DONE only)
//   dividend   in   WIDTH  numerator, sampled on the accepting edge
//   divisor    in   WIDTH  denominator, sampled on the accepting edge
//   signed_op  in   treat operands as signed (SEQ_DIVIDER_SIGNED_EN only)
//   busy       out  division in progress
//   done       out  one-cycle pulse, results valid
//   quotient   out  WIDTH  result quotient (held)
//   remainder  out  WIDTH  result remainder (held)
//   div_zero   out  last accepted operation had divisor == 0 (held)
// Revision : 1.0  initial release
// ============================================================================
module seq_divider #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last_iter;
  logic             div_by_zero;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_r;

  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  assign div_by_zero = (divisor == '0);
  assign last_iter   = (cnt == CNT_W'(WIDTH - 1));

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = div_by_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (last_iter) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = div_by_zero ? S_DONE : S_CALC;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // One restoring step: shift {rem,quo} left, try subtracting the divisor in
  // WIDTH+1 bits; the borrow bit decides whether the subtraction is kept.
  // rem_r < dvs_r always holds, so the shifted remainder never overflows
  // WIDTH bits when the trial fails.
  // --------------------------------------------------------------------------
  always_comb begin
    trial   = {rem_r, quo_r[WIDTH-1]} - {1'b0, dvs_r};
    fits    = ~trial[WIDTH];
    rem_nxt = fits ? trial[WIDTH-1:0] : {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
    quo_nxt = {quo_r[WIDTH-2:0], fits};
  end

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic a_neg;
  logic b_neg;
  logic neg_q_r;
  logic neg_r_r;

  // Magnitudes are divided unsigned; the most negative value maps to itself,
  // which is its correct unsigned magnitude.
  always_comb begin
    a_neg = signed_op & dividend[WIDTH-1];
    b_neg = signed_op & divisor[WIDTH-1];
    a_mag = a_neg ? (~dividend + 1'b1) : dividend;
    b_mag = b_neg ? (~divisor + 1'b1) : divisor;
    q_fin = neg_q_r ? (~quo_nxt + 1'b1) : quo_nxt;
    r_fin = neg_r_r ? (~rem_nxt + 1'b1) : rem_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (accept) begin
      neg_q_r <= a_neg ^ b_neg;
      neg_r_r <= a_neg;
    end
  end
`else
  always_comb begin
    a_mag = dividend;
    b_mag = divisor;
    q_fin = quo_nxt;
    r_fin = rem_nxt;
  end
`endif

  // --------------------------------------------------------------------------
  // Datapath and held results
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      dvs_r     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (accept) begin
      cnt      <= '0;
      rem_r    <= '0;
      quo_r    <= a_mag;
      dvs_r    <= b_mag;
      div_zero <= div_by_zero;
      // Divide by zero completes immediately with the raw dividend.
      if (div_by_zero) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (state == S_CALC) begin
      cnt   <= cnt + 1'b1;
      rem_r <= rem_nxt;
      quo_r <= quo_nxt;
      if (last_iter) begin
        quotient  <= q_fin;
        remainder <= r_fin;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised multi-cycle restoring divider; successor to the team's fixed 5-bit divider.
- Generalised to WIDTH bits.
- Adds a start/busy/done handshake, divide-by-zero flagging, held results, and an optional signed mode.
- Sits between a controller/FSM issuing operands and the datapath consuming quotient/remainder.

Parameters:
- WIDTH, 8, operand and result width in bits (min 2).
- CNT_W, $clog2(WIDTH+1), width of the internal iteration counter (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only in IDLE or DONE.
- dividend  input  WIDTH  numerator; sampled on the accepting edge.
- divisor  input  WIDTH  denominator; sampled on the accepting edge.
- busy  output  1  high while a division is in progress (CALC).
- done  output  1  one-cycle pulse: results valid.
- quotient  output  WIDTH  quotient; held until the next accepted start.
- remainder  output  WIDTH  remainder; held until the next accepted start.
- div_zero  output  1  last accepted operation had divisor==0; held with results.

Behaviour:
- Reset (sync, at clk edge with reset=1): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0, counter=0.
- reset has priority over everything, including mid-CALC; the in-flight operation is abandoned and no done is issued.
- States:
  - IDLE: start=1 with divisor!=0 -> CALC; start=1 with divisor==0 -> DONE.
  - CALC: runs WIDTH iterations, then -> DONE.
  - DONE: start=1 -> accept as in IDLE (back-to-back); else -> IDLE.
- Acceptance edge t0:
  - latch dividend/divisor, clear counter, clear div_zero, busy=1 (CALC path).
- CALC, one iteration per edge (edges t0+1 .. t0+WIDTH):
  - {rem,quo} shifted left 1; trial = rem - divisor in WIDTH+1 bits.
  - If trial non-negative: rem=trial, quo LSB=1; else quo LSB=0.
- Completion, edge t0+WIDTH:
  - state=DONE, quotient/remainder updated, busy=0, done=1 for exactly one cycle.
  - Latency = WIDTH cycles from the accepting edge to done visible.
- Divide by zero:
  - at t0: quotient=all ones, remainder=dividend, div_zero=1, done=1 after t0 (latency 1), busy stays 0.
- start while busy is ignored; operands may change freely during CALC without effect.
- quotient/remainder/div_zero are stable from done until the next accepting edge; they are not cleared on return to IDLE.
- Invariant (unsigned, divisor!=0): dividend == quotient*divisor + remainder, remainder < divisor.
- dividend=0 -> quotient=0, remainder=0 after full WIDTH latency (no early exit).

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined:
  - adds input port signed_op (1 bit, sampled with the operands).
  - When signed_op=1: operands are two's complement; magnitudes are divided unsigned.
  - Quotient is negated if the operand signs differ (truncation toward zero); remainder takes the sign of the dividend.
  - Sign fix-up is applied on the completion edge; latency is unchanged.
  - Overflow case -2^(WIDTH-1) / -1: quotient=-2^(WIDTH-1) (wrapped), remainder=0, div_zero=0.
  - Divide by zero: quotient=all ones, remainder=dividend, regardless of sign.
- Not defined:
  - no signed_op port; unsigned only.

Test Plan:
- WIDTH=5: reset 1 cycle, start with 7/3 -> done pulse exactly 5 cycles after the accepting edge; quotient=2, remainder=1, div_zero=0; busy high for the 5 cycles before done.
- WIDTH=8: 200/7 -> quotient=28, remainder=4; 5/9 -> quotient=0, remainder=5; 255/1 -> quotient=255, remainder=0.
- WIDTH=8: 77/0 -> done 1 cycle after acceptance, quotient=255, remainder=77, div_zero=1; the next op 10/2 clears div_zero, quotient=5.
- Start pulsed and operands changed during CALC of 100/10 -> ignored, result 10 r 0; start held high in the DONE cycle with 9/4 -> accepted back-to-back, result 2 r 1.
- reset asserted 3 cycles into CALC -> all outputs 0 next cycle, no done pulse; a subsequent 6/3 -> quotient=2.
- With SEQ_DIVIDER_SIGNED_EN, WIDTH=8, signed_op=1:
  - -7/2 -> quotient=-3 (0xFD), remainder=-1 (0xFF).
  - 7/-2 -> quotient=-3, remainder=1.
  - -128/-1 -> quotient=0x80, remainder=0.
  - signed_op=0 with 0xF9/2 -> quotient=124, remainder=1.
